// File: rtl/fp32_vec_accumulator.sv
// Streaming FP32 vector reduction: folds each accepted element into a running
// round-to-nearest-even sum and emits one sum, sticky flags and count per vector.
module fp32_vec_accumulator #(
   parameter int WIDTH     = 32,
   parameter int EXP_BITS  = 8,
   parameter int FRAC_BITS = 23,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_flags,
   output logic [CNT_W-1:0] out_count
);

   localparam int MW = FRAC_BITS + 1;   // significand incl. hidden bit
   localparam int SW = MW + 4;          // carry + significand + guard/round/sticky
   localparam int EW = EXP_BITS + 2;    // headroom for carry-out and overflow detection
   localparam logic [EXP_BITS-1:0] EMAX = '1;

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [2:0]         flags_q, flags_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH+2:0]   add_res;

   // Returns {invalid, overflow, inexact, sum}; IEEE RNE addition with subnormals.
   function automatic logic [WIDTH+2:0] fp_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0]    x, y, z;
      logic [EXP_BITS-1:0] ea, eb, xe, ye;
      logic                a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
      logic                sx, sy, inv, ovf, inx, rnd_up, sticky, found;
      logic [EW-1:0]       ex, ey, ez, d;
      logic [MW-1:0]       mx, my;
      logic [SW-1:0]       vx, vy, s, mask;
      logic [MW:0]         mr;
      int                  lz, sh;
      ea     = a[WIDTH-2 -: EXP_BITS];
      eb     = b[WIDTH-2 -: EXP_BITS];
      a_nan  = (ea == EMAX) && (a[FRAC_BITS-1:0] != '0);
      b_nan  = (eb == EMAX) && (b[FRAC_BITS-1:0] != '0);
      a_inf  = (ea == EMAX) && (a[FRAC_BITS-1:0] == '0);
      b_inf  = (eb == EMAX) && (b[FRAC_BITS-1:0] == '0);
      a_snan = a_nan && !a[FRAC_BITS-1];
      b_snan = b_nan && !b[FRAC_BITS-1];
      inv = 1'b0;
      ovf = 1'b0;
      inx = 1'b0;
      z   = '0;
      if (a_nan || b_nan) begin
         z   = {1'b0, EMAX, 1'b1, {(FRAC_BITS-1){1'b0}}};
         inv = a_snan || b_snan;
      end else if (a_inf && b_inf && (a[WIDTH-1] != b[WIDTH-1])) begin
         z   = {1'b0, EMAX, 1'b1, {(FRAC_BITS-1){1'b0}}};
         inv = 1'b1;
      end else if (a_inf) begin
         z = a;
      end else if (b_inf) begin
         z = b;
      end else begin
         // x is the operand of larger magnitude; y is aligned to it
         if (a[WIDTH-2:0] >= b[WIDTH-2:0]) begin
            x = a;
            y = b;
         end else begin
            x = b;
            y = a;
         end
         sx = x[WIDTH-1];
         sy = y[WIDTH-1];
         xe = x[WIDTH-2 -: EXP_BITS];
         ye = y[WIDTH-2 -: EXP_BITS];
         ex = (xe == '0) ? EW'(1) : {2'b00, xe};
         ey = (ye == '0) ? EW'(1) : {2'b00, ye};
         mx = {(xe != '0), x[FRAC_BITS-1:0]};
         my = {(ye != '0), y[FRAC_BITS-1:0]};
         vx = {1'b0, mx, 3'b000};
         vy = {1'b0, my, 3'b000};
         d      = ex - ey;
         mask   = {SW{1'b1}} << d;
         sticky = |(vy & ~mask);
         vy     = (vy >> d) | {{(SW-1){1'b0}}, sticky};
         s      = (sx == sy) ? (vx + vy) : (vx - vy);
         if (s == '0) begin
            z[WIDTH-1] = sx & sy;
         end else begin
            ez = ex;
            if (s[SW-1]) begin
               s  = {1'b0, s[SW-1:2], s[1] | s[0]};
               ez = ez + EW'(1);
            end else begin
               lz    = 0;
               found = 1'b0;
               for (int i = SW - 2; i >= 0; i--) begin
                  if (!found) begin
                     if (s[i]) found = 1'b1;
                     else      lz++;
                  end
               end
               // never normalise below the minimum exponent: leaves a subnormal
               sh = (lz > int'(ez) - 1) ? int'(ez) - 1 : lz;
               s  = s << sh;
               ez = ez - EW'(sh);
            end
            inx    = |s[2:0];
            rnd_up = s[2] & (s[1] | s[0] | s[3]);
            mr     = {1'b0, s[SW-2:3]} + {{MW{1'b0}}, rnd_up};
            if (mr[MW]) begin
               mr = mr >> 1;
               ez = ez + EW'(1);
            end
            if (ez >= {2'b00, EMAX}) begin
               z   = {sx, EMAX, {FRAC_BITS{1'b0}}};
               ovf = 1'b1;
               inx = 1'b1;
            end else begin
               z = {sx, (mr[MW-1] ? ez[EXP_BITS-1:0] : {EXP_BITS{1'b0}}), mr[FRAC_BITS-1:0]};
            end
         end
      end
      return {inv, ovf, inx, z};
   endfunction

   always_comb add_res = fp_add(acc_q, in_data);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      flags_d   = flags_q;
      count_d   = count_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = reset;
            // first element loads raw so a lone -0 is preserved
            if (in_valid) begin
               acc_d   = in_data;
               flags_d = '0;
               count_d = CNT_W'(1);
               state_d = in_last ? OUT : ACC;
            end
         end
         ACC: begin
            in_ready = reset;
            if (in_valid) begin
               acc_d   = add_res[WIDTH-1:0];
               flags_d = flags_q | add_res[WIDTH+2:WIDTH];
               count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
               if (in_last) state_d = OUT;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         flags_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         flags_q <= flags_d;
         count_q <= count_d;
      end
   end

   assign out_data  = acc_q;
   assign out_flags = flags_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_fp32_vec_accumulator.sv
// Directed bench for fp32_vec_accumulator with hand-computed expected sums.
module tb_fp32_vec_accumulator;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_flags;
   logic [15:0] out_count;

   int n_cmp  = 0;
   int n_fail = 0;

   fp32_vec_accumulator #(.WIDTH(32), .EXP_BITS(8), .FRAC_BITS(23), .CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer one element for exactly one cycle; caller is 1ns past a rising edge or at a falling edge.
   task automatic push(input logic [31:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] d,
                             input logic [2:0] f, input logic [15:0] c);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
      check({tag, "_data"}, out_data, d);
      check({tag, "_flags"}, 32'(out_flags), 32'(f));
      check({tag, "_count"}, 32'(out_count), 32'(c));
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_flags", 32'(out_flags), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // 1 + 2 + 3 = 6, with an ignored in_last while idle-valid in between
      out_ready = 1'b1;
      push(32'h3F800000, 1'b0);
      in_last = 1'b1;
      in_data = 32'h7F800000;
      @(posedge clk);
      #1;
      in_last = 1'b0;
      check("t1_hold_ready", 32'(in_ready), 32'd1);
      check("t1_hold_valid", 32'(out_valid), 32'd0);
      push(32'h40000000, 1'b0);
      push(32'h40400000, 1'b1);
      expect_out("t1", 32'h40C00000, 3'b000, 16'd3);
      @(posedge clk);
      #1;
      check("t1_back_ready", 32'(in_ready), 32'd1);
      check("t1_back_valid", 32'(out_valid), 32'd0);

      // single -0 element
      push(32'h80000000, 1'b1);
      expect_out("t2", 32'h80000000, 3'b000, 16'd1);
      @(posedge clk);
      #1;

      // +inf + -inf -> NaN, invalid sticks through +1
      push(32'h7F800000, 1'b0);
      push(32'hFF800000, 1'b0);
      push(32'h3F800000, 1'b1);
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_nan_exp", 32'(out_data[30:23]), 32'hFF);
      check("t3_nan_frac", 32'(|out_data[22:0]), 32'd1);
      check("t3_invalid", 32'(out_flags[2]), 32'd1);
      check("t3_count", 32'(out_count), 32'd3);
      @(posedge clk);
      #1;

      // FLT_MAX + FLT_MAX overflows to +inf
      push(32'h7F7FFFFF, 1'b0);
      push(32'h7F7FFFFF, 1'b1);
      expect_out("t4", 32'h7F800000, 3'b011, 16'd2);
      @(posedge clk);
      #1;

      // 1 + 2^-24 is an exact tie, rounds to even
      push(32'h3F800000, 1'b0);
      push(32'h33800000, 1'b1);
      expect_out("t5", 32'h3F800000, 3'b001, 16'd2);
      @(posedge clk);
      #1;

      // backpressure: outputs stable, inputs blocked despite in_valid
      out_ready = 1'b0;
      push(32'h3F800000, 1'b0);
      push(32'h3F800000, 1'b1);
      in_valid = 1'b1;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 32'h40400000 + 32'(i);
         expect_out("t6_hold", 32'h40000000, 3'b000, 16'd2);
         @(posedge clk);
         #1;
      end
      in_data   = 32'h40400000;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t6_idle_ready", 32'(in_ready), 32'd1);
      check("t6_idle_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      expect_out("t6_next", 32'h40400000, 3'b000, 16'd1);
      @(posedge clk);
      #1;

      // reset mid-vector discards partial state
      push(32'h3F800000, 1'b0);
      push(32'h40000000, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t7_rst_ready", 32'(in_ready), 32'd0);
      check("t7_rst_count", 32'(out_count), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      push(32'h40000000, 1'b1);
      expect_out("t7", 32'h40000000, 3'b000, 16'd1);

      // reset while presenting a result drops out_valid without a clock edge
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("t8_still_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t8_async_valid", 32'(out_valid), 32'd0);
      check("t8_async_data", out_data, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t8_idle_ready", 32'(in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
